dmem_bridge: RTL
================

DMEM_BRIDGE -- requirements
Module: dmem_bridge

Interface
REQ-001 SHALL have parameter: TIMEOUT, 16, maximum cycles from first mem_req to mem_rvalid before a bus error.
REQ-002 SHALL have ports (name direction width meaning):
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- clk_en  in  1  clock enable; when low all state holds.
- data_rd_en_ma  in  1  load in MA stage.
- data_wr_en_ma  in  1  store in MA stage.
- funct3_ma  in  3  access size/sign.
- addr_ma  in  32  byte address.
- wr_data_ma  in  32  store data (rs2).
- rd_data_ma  out  32  aligned, extended load data to WB.
- data_ready  out  1  access complete; low stalls pipeline.
- misaligned  out  1  one-cycle access-fault flag.
- bus_err  out  1  one-cycle timeout flag.
- mem_req  out  1  bus request.
- mem_we  out  1  bus write.
- mem_addr  out  32  word address (addr_ma with [1:0]=0).
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_gnt  in  1  request accepted.
- mem_rvalid  in  1  response valid (loads and stores).
- mem_rdata  in  32  read word.

Function
REQ-003 SHALL implement FSM IDLE, REQ, WAIT_RESP, DONE.
REQ-004 IDLE, no access: data_ready=1, mem_req=0.
REQ-005 IDLE, legal aligned access: mem_req=1 and data_ready=0 combinationally; mem_gnt=1 -> WAIT_RESP, else -> REQ.
REQ-006 REQ: mem_req held with stable addr/we/be/wdata; mem_gnt=1 -> WAIT_RESP.
REQ-007 WAIT_RESP: mem_req=0; mem_rvalid=1 -> capture mem_rdata, -> DONE.
REQ-008 DONE: data_ready=1 for exactly one cycle, rd_data_ma valid, -> IDLE; no re-issue of the same access.
REQ-009 Minimum latency: access in IDLE, gnt same cycle, rvalid next cycle -> data_ready=1 on the third cycle.
REQ-010 Alignment: halfword requires addr[0]=0; word requires addr[1:0]=0.
REQ-011 Fault: misaligned, illegal funct3 (load 011/110/111, store 011-111), or rd and wr both high -> misaligned=1, data_ready=1, no mem_req, stay IDLE.
REQ-012 Byte enables: SB 0001<<addr[1:0]; SH 0011<<addr[1:0]; SW 1111; loads 1111.
REQ-013 mem_wdata: byte replicated x4, halfword replicated x2, word as-is.
REQ-014 Load extraction: LB/LBU select byte at addr[1:0]; LH/LHU select halfword at addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW as-is.
REQ-015 Timeout counter: cleared on leaving IDLE, increments in REQ/WAIT_RESP; when it reaches TIMEOUT-1 -> bus_err=1, data_ready=1 for one cycle, rd_data_ma=0, -> IDLE.
REQ-016 mem_rvalid in IDLE (late response after timeout) SHALL be ignored.
REQ-017 Simultaneous mem_rvalid and timeout expiry: rvalid wins, no bus_err.
REQ-018 Stores complete via mem_rvalid identically to loads; rd_data_ma content don't-care.

Reset
REQ-019 On rst_n low: state=IDLE, counter=0, captured data=0, mem_req=0, misaligned=0, bus_err=0; data_ready=1 while idle.
REQ-020 Reset during REQ/WAIT_RESP SHALL abandon the transaction immediately; responses after release are ignored.

Structure
REQ-021 Shared package SHALL hold memFunct3_e (LB/LH/LW/LBU/LHU, SB/SH/SW), dmemState_e, and DMEM_TIMEOUT default.
REQ-022 Sub-module load_align (combinational extraction/extension from word, addr[1:0], funct3) SHALL be instantiated once.

Verification
REQ-023 LW addr 0x100, gnt same cycle, rvalid+1 with 0xDEADBEEF -> mem_addr 0x100, be 1111, rd_data_ma 0xDEADBEEF, data_ready high cycle 3.
REQ-024 LB addr 0x103, rdata 0x80FF_FF7F -> be 1111, rd_data_ma 0xFFFFFF80; LBU same -> 0x00000080.
REQ-025 SH addr 0x202, data 0x1234ABCD -> mem_addr 0x200, be 1100, mem_wdata 0xABCDABCD, gnt delayed 3 cycles -> req held stable.
REQ-026 LW addr 0x101 -> misaligned=1 one cycle, data_ready=1, mem_req never asserted.
REQ-027 LW, gnt given, no rvalid for 16 cycles -> bus_err pulse, data_ready=1, next-cycle late rvalid ignored.
REQ-028 rst_n asserted in WAIT_RESP -> state IDLE, mem_req=0, subsequent rvalid ignored.

Source files
------------

// File: rtl/dmem_bridge_pkg.sv
// Shared types for the data-memory bridge: funct3 encodings, FSM states, bus command.
// No logic of its own.
package dmem_bridge_pkg;

  localparam int DMEM_TIMEOUT = 16;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } memFunct3_e;

  // Store encodings share values with the signed loads.
  localparam memFunct3_e SB = LB;
  localparam memFunct3_e SH = LH;
  localparam memFunct3_e SW = LW;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_RESP,
    DONE
  } dmemState_e;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [1:0]  off;
    logic [2:0]  funct3;
  } mem_cmd_t;

  function automatic logic access_legal(logic rd, logic wr, logic [2:0] f3, logic [1:0] off);
    logic f3_ok;
    logic align_ok;
    f3_ok    = wr ? (f3 inside {3'b000, 3'b001, 3'b010})
                  : (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    align_ok = (f3[1:0] == 2'b00) ||
               (f3[1:0] == 2'b01 && !off[0]) ||
               (f3[1:0] == 2'b10 && off == 2'b00);
    return !(rd && wr) && f3_ok && align_ok;
  endfunction

endpackage

// File: rtl/load_align.sv
// Load data extraction: selects byte/halfword lane from the read word and extends it.
// Purely combinational, no backpressure.
module load_align
  import dmem_bridge_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[7:0];
    case (off)
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      2'd3:    byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
    half_sel = off[1] ? word[31:16] : word[15:0];

    data = word;
    case (memFunct3_e'(funct3))
      LB:      data = {{24{byte_sel[7]}}, byte_sel};
      LH:      data = {{16{half_sel[15]}}, half_sel};
      LBU:     data = {24'd0, byte_sel};
      LHU:     data = {16'd0, half_sel};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/dmem_bridge.sv
// MA-stage load/store to req/gnt/rvalid bus bridge; min latency 3 cycles (issue, wait, done).
// Pipeline stalls via data_ready=0 while the bus is busy; bus stalls via mem_gnt/mem_rvalid, bounded by TIMEOUT.
module dmem_bridge
  import dmem_bridge_pkg::*;
#(
  parameter int TIMEOUT = DMEM_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_en,
  input  logic        data_rd_en_ma,
  input  logic        data_wr_en_ma,
  input  logic [2:0]  funct3_ma,
  input  logic [31:0] addr_ma,
  input  logic [31:0] wr_data_ma,
  output logic [31:0] rd_data_ma,
  output logic        data_ready,
  output logic        misaligned,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);

  dmemState_e    state_q, state_d;
  logic [CW-1:0] cnt_q;
  mem_cmd_t      cmd_d, cmd_q;
  logic [31:0]   rdata_q, load_data;
  logic          access, legal, timeout;
  logic          launch, capture, req_c, mis_c, berr_c;

  assign access = data_rd_en_ma | data_wr_en_ma;
  assign legal  = access_legal(data_rd_en_ma, data_wr_en_ma, funct3_ma, addr_ma[1:0]);

  always_comb begin
    cmd_d        = '0;
    cmd_d.we     = data_wr_en_ma;
    cmd_d.addr   = {addr_ma[31:2], 2'b00};
    cmd_d.off    = addr_ma[1:0];
    cmd_d.funct3 = funct3_ma;
    cmd_d.be     = 4'b1111;
    cmd_d.wdata  = wr_data_ma;
    if (data_wr_en_ma) begin
      case (funct3_ma[1:0])
        2'b00: begin
          cmd_d.be    = 4'b0001 << addr_ma[1:0];
          cmd_d.wdata = {4{wr_data_ma[7:0]}};
        end
        2'b01: begin
          cmd_d.be    = 4'b0011 << addr_ma[1:0];
          cmd_d.wdata = {2{wr_data_ma[15:0]}};
        end
        default: ;
      endcase
    end
  end

  assign timeout = (state_q == REQ || state_q == WAIT_RESP) && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    state_d    = state_q;
    req_c      = 1'b0;
    data_ready = 1'b0;
    mis_c      = 1'b0;
    berr_c     = 1'b0;
    launch     = 1'b0;
    capture    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!access) begin
          data_ready = 1'b1;
        end else if (!legal) begin
          mis_c      = 1'b1;
          data_ready = 1'b1;
        end else begin
          req_c   = 1'b1;
          launch  = 1'b1;
          state_d = mem_gnt ? WAIT_RESP : REQ;
        end
      end
      REQ: begin
        if (timeout) begin
          berr_c     = 1'b1;
          data_ready = 1'b1;
          state_d    = IDLE;
        end else begin
          req_c = 1'b1;
          if (mem_gnt) state_d = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        // A response arriving on the expiry cycle still completes normally.
        if (mem_rvalid) begin
          capture = 1'b1;
          state_d = DONE;
        end else if (timeout) begin
          berr_c     = 1'b1;
          data_ready = 1'b1;
          state_d    = IDLE;
        end
      end
      DONE: begin
        data_ready = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cmd_q   <= '0;
      rdata_q <= '0;
    end else if (clk_en) begin
      state_q <= state_d;
      if (state_q == REQ || state_q == WAIT_RESP) cnt_q <= cnt_q + 1'b1;
      else                                         cnt_q <= '0;
      if (launch)  cmd_q   <= cmd_d;
      if (capture) rdata_q <= load_data;
    end
  end

  load_align u_load_align (
    .word   (mem_rdata),
    .off    (cmd_q.off),
    .funct3 (cmd_q.funct3),
    .data   (load_data)
  );

  // Bus handshakes only count on enabled cycles, so gate the strobes.
  assign mem_req    = req_c & clk_en;
  assign misaligned = mis_c & clk_en;
  assign bus_err    = berr_c & clk_en;

  assign mem_we     = (state_q == IDLE) ? cmd_d.we    : cmd_q.we;
  assign mem_addr   = (state_q == IDLE) ? cmd_d.addr  : cmd_q.addr;
  assign mem_be     = (state_q == IDLE) ? cmd_d.be    : cmd_q.be;
  assign mem_wdata  = (state_q == IDLE) ? cmd_d.wdata : cmd_q.wdata;
  assign rd_data_ma = (state_q == DONE) ? rdata_q : '0;

endmodule
